// File: rtl/wvb_event_formatter_if.sv
// wvb_event_formatter_if: buffer-reader and output-stream handshake bundle for the event formatter
interface wvb_event_formatter_if #(
    parameter int P_DATA_WIDTH = 22,
    parameter int P_HDR_WIDTH  = 80
);
    logic [P_HDR_WIDTH-1:0]  hdr_data;
    logic                    hdr_empty;
    logic                    hdr_rdreq;
    logic [P_DATA_WIDTH-1:0] wvb_data;
    logic                    wvb_rdreq;
    logic                    wvb_rddone;
    logic [15:0]             dout;
    logic                    dout_valid;
    logic                    dout_ready;
    modport master (
        input  hdr_data, hdr_empty, wvb_data, dout_ready,
        output hdr_rdreq, wvb_rdreq, wvb_rddone, dout, dout_valid
    );
    modport slave (
        output hdr_data, hdr_empty, wvb_data, dout_ready,
        input  hdr_rdreq, wvb_rdreq, wvb_rddone, dout, dout_valid
    );
endinterface

// File: rtl/wvb_event_formatter.sv
// wvb_event_formatter: frames one stored waveform per event into a 16-bit valid/ready word stream
module wvb_event_formatter #(
    parameter int P_DATA_WIDTH = 22,
    parameter int P_HDR_WIDTH  = 80,
    parameter int P_LTC_WIDTH  = 48,
    parameter int P_ADR_WIDTH  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    wvb_event_formatter_if.master bus,
    output logic                  busy,
    output logic [15:0]           evt_cnt,
    output logic                  len_err
);
    typedef enum logic [2:0] {IDLE, HDR, SAMP, TRL, DONE} state_t;
    state_t                 state_q, state_d;
    logic [P_LTC_WIDTH-1:0] ltc_q, ltc_d;
    logic [7:0]             info_q, info_d;
    logic [P_ADR_WIDTH-1:0] n_q, n_d, n_hdr;
    logic [2:0]             idx_q, idx_d;
    logic [P_ADR_WIDTH:0]   cnt_q, cnt_d, cnt_nx;
    logic                   mis_q, mis_d, err_q, err_d, vld_q, vld_d;
    logic [15:0]            dout_q, dout_d, evt_q, evt_d, word, w_hdr, w_smp;
    logic                   load, have, eoe, hit, hdr_rd, smp_rd;
    assign n_hdr  = bus.hdr_data[P_ADR_WIDTH+7 -: P_ADR_WIDTH] - bus.hdr_data[2*P_ADR_WIDTH+7 -: P_ADR_WIDTH] + P_ADR_WIDTH'(1);
    assign eoe    = bus.wvb_data[P_DATA_WIDTH-1];
    assign cnt_nx = cnt_q + (P_ADR_WIDTH+1)'(1);
    // a length field of zero means the whole buffer, so the limit gains its top bit
    assign hit    = cnt_nx == {n_q == '0, n_q};
    assign w_smp  = {eoe, bus.wvb_data[20], |bus.wvb_data[19:12], 1'b0, bus.wvb_data[11:0]};
    assign w_hdr  = idx_q == 3'd0 ? {4'hA, n_q} :
                    idx_q == 3'd1 ? ltc_q[P_LTC_WIDTH-1 -: 16] :
                    idx_q == 3'd2 ? ltc_q[P_LTC_WIDTH-17 -: 16] :
                    idx_q == 3'd3 ? ltc_q[15:0] : {8'h00, info_q};
    assign load   = !vld_q || bus.dout_ready;
    always_comb begin
        state_d = state_q;
        ltc_d   = ltc_q;
        info_d  = info_q;
        n_d     = n_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        err_d   = err_q;
        evt_d   = evt_q;
        hdr_rd  = 1'b0;
        smp_rd  = 1'b0;
        have    = 1'b1;
        word    = w_hdr;
        case (state_q)
            IDLE: begin
                have = 1'b0;
                if (en && !bus.hdr_empty) begin
                    hdr_rd  = 1'b1;
                    ltc_d   = bus.hdr_data[P_HDR_WIDTH-1 -: P_LTC_WIDTH];
                    info_d  = bus.hdr_data[7:0];
                    n_d     = n_hdr;
                    cnt_d   = '0;
                    mis_d   = 1'b0;
                    // W0 leaves straight from the show-ahead header if the output register is free
                    have    = 1'b1;
                    word    = {4'hA, n_hdr};
                    idx_d   = load ? 3'd1 : 3'd0;
                    state_d = HDR;
                end
            end
            HDR: begin
                if (load) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = idx_q == 3'd4 ? SAMP : HDR;
                end
            end
            SAMP: begin
                word = w_smp;
                if (load) begin
                    smp_rd = 1'b1;
                    cnt_d  = cnt_nx;
                    if (eoe || hit) begin
                        mis_d   = eoe != hit;
                        err_d   = err_q | (eoe != hit);
                        state_d = TRL;
                    end
                end
            end
            TRL: begin
                word    = {4'hE, 11'h000, mis_q};
                state_d = load ? DONE : TRL;
            end
            DONE: begin
                have    = 1'b0;
                evt_d   = evt_q + 16'd1;
                state_d = IDLE;
            end
            default: begin
                have    = 1'b0;
                state_d = IDLE;
            end
        endcase
        vld_d  = load ? have : vld_q;
        dout_d = load && have ? word : dout_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ltc_q   <= '0;
            info_q  <= '0;
            n_q     <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
            err_q   <= 1'b0;
            vld_q   <= 1'b0;
            dout_q  <= '0;
            evt_q   <= '0;
        end else begin
            state_q <= state_d;
            ltc_q   <= ltc_d;
            info_q  <= info_d;
            n_q     <= n_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            err_q   <= err_d;
            vld_q   <= vld_d;
            dout_q  <= dout_d;
            evt_q   <= evt_d;
        end
    end
    assign bus.hdr_rdreq  = hdr_rd && !rst;
    assign bus.wvb_rdreq  = smp_rd && !rst;
    assign bus.wvb_rddone = state_q == DONE && !rst;
    assign bus.dout       = dout_q;
    assign bus.dout_valid = vld_q;
    assign busy           = state_q == HDR || state_q == SAMP || state_q == TRL;
    assign evt_cnt        = evt_q;
    assign len_err        = err_q;
endmodule

// File: tb/tb_wvb_event_formatter.sv
// tb_wvb_event_formatter: directed and randomized events scored against a word-list model of the framing rules
module tb_wvb_event_formatter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b0;
    logic        busy, len_err;
    logic [15:0] evt_cnt;
    wvb_event_formatter_if bus();
    wvb_event_formatter dut (.clk(clk), .rst(rst), .en(en), .bus(bus), .busy(busy), .evt_cnt(evt_cnt), .len_err(len_err));
    always #5 clk = ~clk;

    int          n_chk = 0, n_fail = 0;
    logic [79:0] hq[$];
    int          pend_len[$];
    logic [21:0] pend_s[$], sq[$];
    logic [15:0] exp_q[$], got[$];
    int          exp_evt = 0, exp_samp = 0;
    bit          exp_err = 0;
    int          hdr_cnt = 0, rd_cnt = 0, done_cnt = 0;
    int          rmode = 0;
    bit          pop_h = 0, pop_s = 0;
    logic [15:0] ref1 [10] = '{16'hA004, 16'h1234, 16'h5678, 16'h9ABC, 16'h0080,
                               16'h0001, 16'h0002, 16'h0003, 16'h8004, 16'hE000};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic drive_up();
        bus.hdr_empty = hq.size() == 0;
        bus.hdr_data  = hq.size() != 0 ? hq[0] : '0;
        bus.wvb_data  = sq.size() != 0 ? sq[0] : '0;
    endtask

    task automatic clear_model();
        hq.delete(); pend_len.delete(); pend_s.delete(); sq.delete(); exp_q.delete(); got.delete();
        exp_evt = 0; exp_samp = 0; exp_err = 0; hdr_cnt = 0; rd_cnt = 0; done_cnt = 0;
        drive_up();
    endtask

    // Builds the upstream waveform and appends the words the framing rules demand for it.
    task automatic add_event(input logic [47:0] ltc, input logic [11:0] st, input logic [11:0] sp,
                             input logic [1:0] tr, input logic [5:0] fl, input int eoe_at, input bit rnd);
        int n, lim, ns;
        bit mis;
        logic [21:0] s;
        @(posedge clk); #1;
        n   = (int'(sp) - int'(st) + 1) & 32'hFFF;
        lim = n == 0 ? 4096 : n;
        ns  = eoe_at >= 0 ? eoe_at + 1 : lim + 2;
        mis = 1;
        hq.push_back({ltc, st, sp, tr, fl});
        pend_len.push_back(ns);
        exp_q.push_back(16'hA000 | 16'(n));
        exp_q.push_back(ltc[47:32]);
        exp_q.push_back(ltc[31:16]);
        exp_q.push_back(ltc[15:0]);
        exp_q.push_back({8'h00, tr, fl});
        for (int k = 0; k < ns; k++) begin
            s = '0;
            s[11:0]  = rnd ? 12'($urandom) : 12'(k + 1);
            s[19:12] = rnd ? 8'($urandom) : 8'h00;
            s[20]    = rnd ? 1'($urandom) : 1'b0;
            s[21]    = k == eoe_at;
            pend_s.push_back(s);
        end
        for (int k = 0; k < ns; k++) begin
            s = pend_s[pend_s.size() - ns + k];
            exp_q.push_back({s[21], s[20], |s[19:12], 1'b0, s[11:0]});
            exp_samp++;
            if (s[21] || k + 1 == lim) begin
                mis = !(s[21] && k + 1 == lim);
                break;
            end
        end
        exp_q.push_back(16'hE000 | 16'(mis));
        exp_err = exp_err | mis;
        exp_evt++;
        drive_up();
    endtask

    task automatic wait_idle(input int lim);
        int c = 0;
        while ((exp_q.size() != 0 || hq.size() != 0 || busy || bus.dout_valid) && c < lim) begin
            @(posedge clk); #2;
            c++;
        end
        chk("drain_in_time", 32'(c < lim), 1);
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic quiet_chk();
        chk("evt_cnt", evt_cnt, 32'(16'(exp_evt)));
        chk("len_err", len_err, exp_err);
        chk("hdr_pulses", hdr_cnt, exp_evt);
        chk("rddone_pulses", done_cnt, exp_evt);
        chk("rdreq_pulses", rd_cnt, exp_samp);
    endtask

    task automatic cmp_lit(input string nm, input logic [15:0] r [10]);
        chk({nm, "_len"}, got.size(), 10);
        for (int i = 0; i < 10; i++) chk({nm, "_word"}, i < got.size() ? got[i] : 16'hxxxx, r[i]);
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        clear_model();
    endtask

    // Scoreboard/monitor: samples mid-cycle, checks stream words and handshake rules.
    initial begin
        logic [15:0] pd;
        bit stall, w0;
        stall = 0; w0 = 0; pd = '0;
        forever begin
            @(negedge clk);
            pop_h = 0; pop_s = 0;
            if (rst) begin
                stall = 0; w0 = 0;
            end else begin
                if (stall) begin
                    chk("stall_valid", bus.dout_valid, 1);
                    chk("stall_hold", bus.dout, pd);
                end
                if (w0) chk("w0_latency", {bus.dout_valid, bus.dout[15:12]}, 5'h1A);
                if (bus.wvb_rdreq) chk("rdreq_in_load", 32'(!bus.dout_valid || bus.dout_ready), 1);
                if (bus.dout_valid && bus.dout_ready) begin
                    got.push_back(bus.dout);
                    if (exp_q.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL stream_extra: got %h, want no word", bus.dout);
                    end else chk("stream", bus.dout, exp_q.pop_front());
                end
                stall = bus.dout_valid && !bus.dout_ready;
                pd    = bus.dout;
                w0    = bus.hdr_rdreq && (!bus.dout_valid || bus.dout_ready);
                hdr_cnt  += int'(bus.hdr_rdreq);
                rd_cnt   += int'(bus.wvb_rdreq);
                done_cnt += int'(bus.wvb_rddone);
                pop_h = bus.hdr_rdreq;
                pop_s = bus.wvb_rdreq;
            end
        end
    end

    // Upstream buffer and consumer: apply pops seen last cycle, then drive ready.
    initial begin
        int ph = 0;
        forever begin
            @(posedge clk); #1;
            if (pop_h && hq.size() != 0) begin
                hq.delete(0);
                sq.delete();
                repeat (pend_len[0]) sq.push_back(pend_s.pop_front());
                pend_len.delete(0);
            end
            if (pop_s && sq.size() != 0) sq.delete(0);
            ph = (ph + 1) % 13;
            bus.dout_ready = rmode == 0 ? 1'b1 :
                             rmode == 1 ? (ph < 8 && ph % 2 == 0) : ($urandom_range(0, 3) != 0);
            drive_up();
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int h0, d0;
        bus.dout_ready = 1'b1;
        drive_up();
        do_reset();
        @(negedge clk);
        chk("rst_dout", bus.dout, 0);
        chk("rst_valid", bus.dout_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_evt_cnt", evt_cnt, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_rddone", bus.wvb_rddone, 0);
        // single event, ready held high
        en = 1; rmode = 0;
        add_event(48'h123456789ABC, 12'h010, 12'h013, 2'd2, 6'd0, 3, 0);
        wait_idle(200);
        cmp_lit("single", ref1);
        chk("single_evt_cnt", evt_cnt, 1);
        chk("single_rdreq", rd_cnt, 4);
        chk("single_hdr", hdr_cnt, 1);
        chk("single_done", done_cnt, 1);
        quiet_chk();
        // same event under backpressure
        got.delete(); rmode = 1;
        add_event(48'h123456789ABC, 12'h010, 12'h013, 2'd2, 6'd0, 3, 0);
        wait_idle(400);
        cmp_lit("bp", ref1);
        chk("bp_rdreq", rd_cnt, 8);
        quiet_chk();
        // address wrap and full buffer
        got.delete(); rmode = 2;
        add_event({16'($urandom), 32'($urandom)}, 12'hFFE, 12'h001, 2'd1, 6'h2A, 3, 1);
        wait_idle(400);
        chk("wrap_w0", got.size() != 0 ? got[0] : 16'hxxxx, 16'hA004);
        chk("wrap_len", got.size(), 10);
        got.delete(); rmode = 0;
        add_event({16'($urandom), 32'($urandom)}, 12'h005, 12'h004, 2'd3, 6'h15, 4095, 1);
        wait_idle(6000);
        chk("full_w0", got.size() != 0 ? got[0] : 16'hxxxx, 16'hA000);
        chk("full_len", got.size(), 4102);
        chk("full_trl", got.size() == 4102 ? got[4101] : 16'hxxxx, 16'hE000);
        quiet_chk();
        // early eoe, then a clean event keeps the sticky flag
        got.delete();
        add_event(48'h0000_0000_0001, 12'h010, 12'h013, 2'd0, 6'd0, 1, 0);
        wait_idle(200);
        chk("short_len", got.size(), 8);
        chk("short_trl", got.size() == 8 ? got[7] : 16'hxxxx, 16'hE001);
        chk("short_len_err", len_err, 1);
        got.delete();
        add_event(48'h0000_0000_0002, 12'h100, 12'h101, 2'd0, 6'd0, 1, 0);
        wait_idle(200);
        chk("good_trl", got.size() == 8 ? got[7] : 16'hxxxx, 16'hE000);
        chk("sticky_len_err", len_err, 1);
        // count reaches n without eoe
        got.delete();
        add_event(48'h0000_0000_0003, 12'h010, 12'h012, 2'd0, 6'd0, -1, 0);
        wait_idle(200);
        chk("noeoe_len", got.size(), 9);
        chk("noeoe_trl", got.size() == 9 ? got[8] : 16'hxxxx, 16'hE001);
        quiet_chk();
        // randomized events, random ready
        rmode = 2;
        for (int e = 0; e < 40; e++) begin
            logic [11:0] st;
            int len, ea;
            st  = 12'($urandom);
            len = $urandom_range(1, 12);
            ea  = $urandom_range(0, 4) != 0 ? len - 1 : $urandom_range(0, len + 1);
            if (ea >= len) ea = -1;
            add_event({16'($urandom), 32'($urandom)}, st, st + 12'(len - 1), 2'($urandom), 6'($urandom), ea, 1);
            if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 30)) @(posedge clk);
        end
        wait_idle(20000);
        quiet_chk();
        // enable gating
        rmode = 0;
        @(posedge clk); #1 en = 0;
        h0 = hdr_cnt; d0 = done_cnt;
        add_event(48'h0000_0000_0004, 12'h200, 12'h203, 2'd1, 6'd1, 3, 1);
        repeat (20) @(posedge clk);
        #2;
        chk("en_gate_hdr", hdr_cnt, h0);
        chk("en_gate_busy", busy, 0);
        @(posedge clk); #1 en = 1;
        c = 0;
        while (!busy && c < 20) begin @(posedge clk); #2; c++; end
        chk("en_start", busy, 1);
        @(posedge clk); #1 en = 0;
        add_event(48'h0000_0000_0005, 12'h300, 12'h302, 2'd2, 6'd2, 2, 1);
        repeat (60) @(posedge clk);
        #2;
        chk("en_drop_hdr", hdr_cnt, h0 + 1);
        chk("en_drop_done", done_cnt, d0 + 1);
        chk("en_drop_busy", busy, 0);
        @(posedge clk); #1 en = 1;
        wait_idle(400);
        quiet_chk();
        // reset in the middle of the sample phase
        do_reset();
        add_event(48'hABCD_0000_1234, 12'h040, 12'h047, 2'd1, 6'd3, 7, 1);
        c = 0;
        while (rd_cnt < 3 && c < 50) begin @(posedge clk); #2; c++; end
        chk("mrst_in_samp", busy, 1);
        @(posedge clk); #1 rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("mrst_dout", bus.dout, 0);
        chk("mrst_valid", bus.dout_valid, 0);
        chk("mrst_busy", busy, 0);
        chk("mrst_hdr_rdreq", bus.hdr_rdreq, 0);
        chk("mrst_rdreq", bus.wvb_rdreq, 0);
        chk("mrst_rddone", bus.wvb_rddone, 0);
        chk("mrst_evt_cnt", evt_cnt, 0);
        chk("mrst_done_cnt", done_cnt, 0);
        @(posedge clk); #1 rst = 0;
        clear_model();
        add_event(48'h1111_2222_3333, 12'h050, 12'h051, 2'd0, 6'd0, 1, 0);
        wait_idle(200);
        chk("post_rst_w0", got.size() != 0 ? got[0] : 16'hxxxx, 16'hA002);
        chk("post_rst_trl", got.size() == 8 ? got[7] : 16'hxxxx, 16'hE000);
        chk("post_rst_evt", evt_cnt, 1);
        quiet_chk();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
